// File: rtl/packer_pkg.sv
// ---------------------------------------------------------------------------
// packer_pkg
// Shared definitions for the symbol packer:
//   - default symbol width / symbols-per-word
//   - clog2 constant function for deriving counter widths
//   - slot_lsb(): bit offset of a symbol slot for either packing order
//   - pack_act_e: the single action the accumulator takes on a clock edge
// ---------------------------------------------------------------------------
package packer_pkg;

  localparam int DEF_SYM_W   = 2;
  localparam int DEF_NUM_SYM = 8;

  // Ceiling log2, with a minimum result of 1 so widths never collapse to 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  // LSB position of slot k. Slot 0 sits at the bottom of the word when
  // msb_first is clear, and at the top when it is set.
  function automatic int slot_lsb(input int k, input bit msb_first,
                                  input int sym_w, input int num_sym);
    if (msb_first) begin
      return (num_sym - 1 - k) * sym_w;
    end
    return k * sym_w;
  endfunction

  // What happens to the accumulator on the coming edge. Exactly one applies.
  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,  // nothing accepted, nothing held to move
    ACT_ACCUM = 3'd1,  // symbol accepted into a word that is not yet full
    ACT_EMIT  = 3'd2,  // symbol completes a word, output slot is free
    ACT_HOLD  = 3'd3,  // symbol completes a word, output slot is busy
    ACT_DRAIN = 3'd4   // previously held word moves into the output slot
  } pack_act_e;

endpackage

// File: rtl/packer_out_reg.sv
// ---------------------------------------------------------------------------
// packer_out_reg
// Output register stage of the symbol packer. Holds one completed word with
// a valid/ready handshake; the held word stays stable until consumed.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            load a new word this edge (only asserted when avail=1)
//   load_data/count/last  word to load
//   out_ready       consumer accepts the current word
//   avail           register can take a word on this edge
//   out_valid/data/count/last  registered word towards the consumer
// ---------------------------------------------------------------------------
module packer_out_reg #(
  parameter int W     = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             avail,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last
);

  // Free when empty, or when the current word leaves on this same edge.
  assign avail = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_count <= load_count;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/symbol_packer.sv
// ---------------------------------------------------------------------------
// symbol_packer
// Serial-to-parallel packer: collects SYM_W-bit symbols into words of
// NUM_SYM symbols, with valid/ready on both sides. in_last terminates a
// frame early and emits a zero-filled partial word.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_sym                input symbol
//   in_last               symbol ends the frame; flush the word
//   out_valid/out_ready   output handshake
//   out_data              packed word, unused slots zero
//   out_count             valid symbols in the word (1..NUM_SYM)
//   out_last              word ends a frame
//
// A completed word goes straight to the output register when it is free.
// Otherwise it stays in the accumulator (pend) and input is stalled until
// the output register frees up, so one word is buffered beyond the output.
// ---------------------------------------------------------------------------
module symbol_packer
  import packer_pkg::*;
#(
  parameter int   SYM_W     = DEF_SYM_W,
  parameter int   NUM_SYM   = DEF_NUM_SYM,
  parameter bit   MSB_FIRST = 1'b0,
  localparam int  CNT_W     = clog2(NUM_SYM + 1),
  localparam int  W         = SYM_W * NUM_SYM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last
);

  // Accumulator
  logic [W-1:0]     acc_data;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_last;
  logic             pend;

  logic             accept;
  logic             last_slot;
  logic             complete;
  logic             avail;
  logic [W-1:0]     sym_ext;
  logic [W-1:0]     merged;
  logic [CNT_W-1:0] cnt_inc;
  pack_act_e        act;

  logic             load;
  logic [W-1:0]     load_data;
  logic [CNT_W-1:0] load_count;
  logic             load_last;

  assign in_ready  = !pend;
  assign accept    = in_valid && !pend;
  assign last_slot = (acc_cnt == CNT_W'(NUM_SYM - 1));
  assign complete  = accept && (last_slot || in_last);
  assign cnt_inc   = acc_cnt + CNT_W'(1);

  // Unfilled accumulator slots are always zero, so OR-ing the shifted symbol
  // in both places it and keeps partial words zero-filled.
  assign sym_ext = {{(W - SYM_W){1'b0}}, in_sym};
  assign merged  = acc_data
                 | (sym_ext << slot_lsb(int'(acc_cnt), MSB_FIRST, SYM_W, NUM_SYM));

  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    act = ACT_NONE;
    if (pend) begin
      if (avail) begin
        act = ACT_DRAIN;
      end
    end else if (complete) begin
      act = avail ? ACT_EMIT : ACT_HOLD;
    end else if (accept) begin
      act = ACT_ACCUM;
    end
  end

  // Output-register load: either the freshly merged word or the held one.
  always_comb begin
    load       = 1'b0;
    load_data  = merged;
    load_count = cnt_inc;
    load_last  = in_last;
    case (act)
      ACT_EMIT: begin
        load = 1'b1;
      end
      ACT_DRAIN: begin
        load       = 1'b1;
        load_data  = acc_data;
        load_count = acc_cnt;
        load_last  = acc_last;
      end
      default: begin
      end
    endcase
  end

  // NOTE: acc_data is reset as well as the control bits, because the merge
  // relies on empty slots being zero; a stale bit would corrupt the next word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_data <= '0;
      acc_cnt  <= '0;
      acc_last <= 1'b0;
      pend     <= 1'b0;
    end else begin
      case (act)
        ACT_ACCUM: begin
          acc_data <= merged;
          acc_cnt  <= cnt_inc;
        end
        ACT_HOLD: begin
          acc_data <= merged;
          acc_cnt  <= cnt_inc;
          acc_last <= in_last;
          pend     <= 1'b1;
        end
        ACT_EMIT, ACT_DRAIN: begin
          acc_data <= '0;
          acc_cnt  <= '0;
          acc_last <= 1'b0;
          pend     <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  packer_out_reg #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .load_last  (load_last),
    .out_ready  (out_ready),
    .avail      (avail),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_symbol_packer.sv
// ---------------------------------------------------------------------------
// tb_symbol_packer
// Drives identical stimulus into an LSB-first and an MSB-first packer.
// A reference model builds the expected words for both orders as symbols
// are accepted and queues them; words are popped and compared as the DUTs
// hand them over. Directed checks cover reset, latency, stall and flush.
// ---------------------------------------------------------------------------
module tb_symbol_packer;

  localparam int SYM_W   = 2;
  localparam int NUM_SYM = 8;
  localparam int W       = SYM_W * NUM_SYM;
  localparam int CNT_W   = 4;

  typedef struct {
    logic [W-1:0]     data_l;
    logic [W-1:0]     data_m;
    logic [CNT_W-1:0] count;
    logic             last;
  } word_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             in_last;
  logic             out_ready;

  logic             in_ready_l,  in_ready_m;
  logic             out_valid_l, out_valid_m;
  logic [W-1:0]     out_data_l,  out_data_m;
  logic [CNT_W-1:0] out_count_l, out_count_m;
  logic             out_last_l,  out_last_m;

  int n_checks;
  int n_fail;
  int stall_cycles;
  int pops;

  word_t            sb[$];
  int               mdl_cnt;
  logic [W-1:0]     mdl_l;
  logic [W-1:0]     mdl_m;
  logic             hold;
  logic [W-1:0]     hold_data;

  symbol_packer #(.SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .out_count(out_count_l), .out_last(out_last_l)
  );

  symbol_packer #(.SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .out_count(out_count_m), .out_last(out_last_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    mdl_cnt = 0;
    mdl_l   = '0;
    mdl_m   = '0;
  endtask

  // Scoreboard monitor; sampled on the falling edge, where all handshake
  // signals are stable and show what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(out_valid_l), 32'd1);
        check("hold_data", 32'(out_data_l), 32'(hold_data));
      end
      if (out_valid_l && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_word", 32'(sb.size()), 32'd1);
        end else begin
          word_t e;
          e = sb.pop_front();
          pops++;
          check("word_data_lsb", 32'(out_data_l), 32'(e.data_l));
          check("word_data_msb", 32'(out_data_m), 32'(e.data_m));
          check("word_count", 32'(out_count_l), 32'(e.count));
          check("word_last", 32'(out_last_l), 32'(e.last));
          check("msb_valid", 32'(out_valid_m), 32'd1);
        end
      end
      if (in_valid && in_ready_l) begin
        word_t w;
        mdl_l = mdl_l | (W'(in_sym) << (mdl_cnt * SYM_W));
        mdl_m = mdl_m | (W'(in_sym) << ((NUM_SYM - 1 - mdl_cnt) * SYM_W));
        mdl_cnt++;
        if (mdl_cnt == NUM_SYM || in_last) begin
          w.data_l = mdl_l;
          w.data_m = mdl_m;
          w.count  = CNT_W'(mdl_cnt);
          w.last   = in_last;
          sb.push_back(w);
          mdl_cnt = 0;
          mdl_l   = '0;
          mdl_m   = '0;
        end
      end
      hold      = out_valid_l && !out_ready;
      hold_data = out_data_l;
    end
  end

  // Offer one symbol and return #1 after the edge that accepts it.
  task automatic send(input logic [SYM_W-1:0] s, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sym   = s;
    in_last  = l;
    @(negedge clk);
    while (!in_ready_l && n < 200) begin
      stall_cycles++;
      n++;
      @(negedge clk);
    end
    if (!in_ready_l) begin
      check("send_wait_in_ready", 32'(in_ready_l), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SYM_W-1:0] seq6 [8];
    n_checks = 0;
    n_fail = 0;
    stall_cycles = 0;
    pops = 0;
    hold = 1'b0;
    model_clear();
    rst = 1'b0;
    in_valid = 1'b0;
    in_sym = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    idle(2);

    // Reset state
    check("rst_out_valid", 32'(out_valid_l), 32'd0);
    check("rst_out_data", 32'(out_data_l), 32'd0);
    check("rst_out_count", 32'(out_count_l), 32'd0);
    check("rst_out_last", 32'(out_last_l), 32'd0);
    check("rst_in_ready", 32'(in_ready_l), 32'd1);
    rst = 1'b1;
    idle(2);

    // Full word, both orders, latency one edge
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(SYM_W'(i % 4), 1'b0);
      if (i == 6) check("t1_valid_before_8th", 32'(out_valid_l), 32'd0);
    end
    check("t1_valid_after_8th", 32'(out_valid_l), 32'd1);
    check("t1_data_lsb", 32'(out_data_l), 32'h0000_E4E4);
    check("t2_data_msb", 32'(out_data_m), 32'h0000_1B1B);
    check("t1_count", 32'(out_count_l), 32'd8);
    check("t1_last", 32'(out_last_l), 32'd0);
    idle(3);

    // Early termination, zero fill, restart at slot 0
    send(2'd3, 1'b0);
    send(2'd2, 1'b0);
    send(2'd1, 1'b1);
    check("t3_data_lsb", 32'(out_data_l), 32'h0000_001B);
    check("t3_data_msb", 32'(out_data_m), 32'h0000_E400);
    check("t3_count", 32'(out_count_l), 32'd3);
    check("t3_last", 32'(out_last_l), 32'd1);
    send(2'd2, 1'b1);
    check("t3_next_slot0", 32'(out_data_l), 32'h0000_0002);
    check("t3_next_count", 32'(out_count_l), 32'd1);
    idle(3);

    // Back-pressure: one word in output, one held, 17th stalled
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(SYM_W'(i % 4), 1'b0);
    check("t4_in_ready_low", 32'(in_ready_l), 32'd0);
    check("t4_out_valid", 32'(out_valid_l), 32'd1);
    in_valid = 1'b1;
    in_sym   = 2'd3;
    in_last  = 1'b1;
    idle(3);
    check("t4_still_stalled", 32'(in_ready_l), 32'd0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("t4_in_ready_back", 32'(in_ready_l), 32'd1);
    check("t4_word2_valid", 32'(out_valid_l), 32'd1);
    check("t4_word2_count", 32'(out_count_l), 32'd8);
    idle(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_17th_taken_pend", 32'(in_ready_l), 32'd0);
    out_ready = 1'b1;
    idle(4);
    check("t4_sb_drained", 32'(sb.size()), 32'd0);

    // Sustained throughput
    begin
      int pops0;
      pops0 = pops;
      stall_cycles = 0;
      for (int i = 0; i < 64; i++) send(SYM_W'($urandom_range(0, 3)), 1'b0);
      idle(3);
      check("t5_no_stalls", 32'(stall_cycles), 32'd0);
      check("t5_words", 32'(pops - pops0), 32'd8);
    end

    // Reset mid-word with a word held in the output
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send(SYM_W'(3 - (i % 4)), 1'b0);
    rst = 1'b0;
    #1;
    model_clear();
    check("t6_out_valid", 32'(out_valid_l), 32'd0);
    check("t6_in_ready", 32'(in_ready_l), 32'd1);
    check("t6_out_data", 32'(out_data_l), 32'd0);
    idle(2);
    rst = 1'b1;
    out_ready = 1'b1;
    idle(1);
    seq6 = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 8; i++) send(seq6[i], 1'b0);
    check("t6_fresh_data", 32'(out_data_l), 32'h0000_05AF);
    check("t6_fresh_count", 32'(out_count_l), 32'd8);
    idle(3);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_in_ready", 32'(in_ready_l), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
